// File: rtl/fhs_clk_tx_pkg.sv
// Shared types and field geometry for the master-side FHS CLK field transmitter.
package fhs_clk_tx_pkg;

    localparam int FHS_CLK_W   = 26;
    localparam int FHS_CLK_LSB = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WAIT_FLD,
        SHIFT
    } state_t;

endpackage

// File: rtl/fhs_clk_ser.sv
// Parallel-load, LSB-first serializer with a saturating bit counter.
// Every shift edge registers the next bit; last flags that all W bits are out.
module fhs_clk_ser
    import fhs_clk_tx_pkg::*;
#(
    parameter int W = FHS_CLK_W
) (
    input  logic         clk_6M,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         start,
    input  logic         shift,
    input  logic         clear,
    output logic         ser_bit,
    output logic         ser_vld,
    output logic         last
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     sr;
    logic [CNT_W-1:0] cnt;

    assign last = (cnt == CNT_W'(W));

    // NOTE: state uses <= so every register samples pre-edge values; later ifs override earlier ones.
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            ser_bit <= 1'b0;
            ser_vld <= 1'b0;
        end else begin
            if (load) begin
                sr  <= load_val;
                cnt <= '0;
            end
            if (start) begin
                cnt <= '0;
            end
            if (shift && !last) begin
                ser_bit <= sr[0];
                ser_vld <= 1'b1;
                sr      <= sr >> 1;
                cnt     <= cnt + CNT_W'(1);
            end
            if (clear) begin
                ser_bit <= 1'b0;
                ser_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fhs_clk_tx.sv
// FHS CLK field transmitter: snapshots CLK_master[27:2]+1 at the next master TX
// slot start and serializes it LSB first, one bit per p_1us tick.
module fhs_clk_tx
    import fhs_clk_tx_pkg::*;
#(
    parameter int FLD_W     = FHS_CLK_W,
    parameter int TMO_SLOTS = 2
) (
    input  logic             clk_6M,
    input  logic             rst,
    input  logic             p_1us,
    input  logic [27:0]      CLK_master,
    input  logic             Master_RX_tslot_endp,
    input  logic             m_tslot_p,
    input  logic             fhs_req_p,
    input  logic             fhs_abort_p,
    input  logic             fld_start_p,
    output logic             clk_bit,
    output logic             clk_bit_vld,
    output logic [FLD_W-1:0] fhs_CLK_snap,
    output logic             busy,
    output logic             done_p,
    output logic             err_p
);

    localparam int SLOT_W = $clog2(TMO_SLOTS + 1);

    state_t            state, state_nxt;
    logic [SLOT_W-1:0] slot_cnt;
    logic [FLD_W-1:0]  snap_val;
    logic              load, start, shift, clear, last;
    logic              slot_clr, slot_inc, done_nxt, err_nxt;
    logic              unused_clk_lsb;

    // CLK ticks on the same edge that opens the TX slot, so the field carries the next value.
    assign snap_val       = CLK_master[FHS_CLK_LSB +: FLD_W] + FLD_W'(1);
    assign unused_clk_lsb = ^CLK_master[FHS_CLK_LSB-1:0];
    assign busy           = (state != IDLE);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        start     = 1'b0;
        shift     = 1'b0;
        clear     = 1'b0;
        slot_clr  = 1'b0;
        slot_inc  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (state != IDLE && fhs_abort_p) begin
            state_nxt = IDLE;
            clear     = 1'b1;
            err_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (fhs_req_p) state_nxt = ARMED;
                end
                ARMED: begin
                    if (Master_RX_tslot_endp) begin
                        load      = 1'b1;
                        slot_clr  = 1'b1;
                        state_nxt = WAIT_FLD;
                    end
                end
                WAIT_FLD: begin
                    if (fld_start_p) begin
                        start     = 1'b1;
                        state_nxt = SHIFT;
                    end else if (m_tslot_p) begin
                        if (slot_cnt == SLOT_W'(TMO_SLOTS - 1)) begin
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            slot_inc = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (p_1us) begin
                        if (last) begin
                            clear     = 1'b1;
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            shift = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state        <= IDLE;
            slot_cnt     <= '0;
            fhs_CLK_snap <= '0;
            done_p       <= 1'b0;
            err_p        <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_p <= done_nxt;
            err_p  <= err_nxt;
            if (load)     fhs_CLK_snap <= snap_val;
            if (slot_clr) slot_cnt     <= '0;
            else if (slot_inc) slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    fhs_clk_ser #(
        .W (FLD_W)
    ) u_ser (
        .clk_6M   (clk_6M),
        .rst      (rst),
        .load     (load),
        .load_val (snap_val),
        .start    (start),
        .shift    (shift),
        .clear    (clear),
        .ser_bit  (clk_bit),
        .ser_vld  (clk_bit_vld),
        .last     (last)
    );

endmodule

// File: tb/tb_fhs_clk_tx.sv
// Scoreboard bench for fhs_clk_tx: expected field bits are queued at snapshot time
// and popped on every bit the DUT presents after a p_1us tick.
module tb_fhs_clk_tx;

    logic        clk_6M = 1'b0;
    logic        rst = 1'b1;
    logic        p_1us = 1'b0;
    logic [27:0] CLK_master = '0;
    logic        Master_RX_tslot_endp = 1'b0;
    logic        m_tslot_p = 1'b0;
    logic        fhs_req_p = 1'b0;
    logic        fhs_abort_p = 1'b0;
    logic        fld_start_p = 1'b0;
    logic        clk_bit, clk_bit_vld, busy, done_p, err_p;
    logic [25:0] fhs_CLK_snap;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_q[$];
    int   bits_popped = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   busy_falls = 0;
    logic vld_seen = 1'b0;

    fhs_clk_tx dut (
        .clk_6M               (clk_6M),
        .rst                  (rst),
        .p_1us                (p_1us),
        .CLK_master           (CLK_master),
        .Master_RX_tslot_endp (Master_RX_tslot_endp),
        .m_tslot_p            (m_tslot_p),
        .fhs_req_p            (fhs_req_p),
        .fhs_abort_p          (fhs_abort_p),
        .fld_start_p          (fld_start_p),
        .clk_bit              (clk_bit),
        .clk_bit_vld          (clk_bit_vld),
        .fhs_CLK_snap         (fhs_CLK_snap),
        .busy                 (busy),
        .done_p               (done_p),
        .err_p                (err_p)
    );

    always #5 clk_6M = ~clk_6M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Free-running 1 us tick: one cycle high out of six.
    initial begin
        int ph = 0;
        forever begin
            @(negedge clk_6M);
            ph    = (ph == 5) ? 0 : ph + 1;
            p_1us = (ph == 0);
        end
    end

    // Output monitor, sampled 1 time unit after each active edge.
    initial begin
        logic tick_q, rst_q, vld_prev, busy_prev;
        vld_prev  = 1'b0;
        busy_prev = 1'b0;
        forever begin
            @(posedge clk_6M);
            tick_q = p_1us;
            rst_q  = rst;
            #1;
            if (clk_bit_vld) vld_seen = 1'b1;
            if (clk_bit_vld && !vld_prev) check("first_bit_lat", 32'(tick_q), 1);
            if (!rst_q && tick_q && clk_bit_vld) begin
                if (exp_q.size() == 0) begin
                    check("bit_extra", 32'(clk_bit_vld), 0);
                end else begin
                    check($sformatf("bit%0d", bits_popped), 32'(clk_bit), 32'(exp_q.pop_front()));
                    bits_popped++;
                end
            end
            if (done_p || err_p) check("done_err_excl", 32'(done_p && err_p), 0);
            if (done_p) begin
                done_cnt++;
                check("done_lat", 32'(tick_q), 1);
                check("vld_at_done", 32'(clk_bit_vld), 0);
                check("bits_left_at_done", exp_q.size(), 0);
            end
            if (err_p) err_cnt++;
            if (busy_prev && !busy) busy_falls++;
            vld_prev  = clk_bit_vld;
            busy_prev = busy;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_6M);
    endtask

    task automatic pulse(input logic req, input logic endp, input logic tslot,
                         input logic fstart, input logic abort);
        fhs_req_p            = req;
        Master_RX_tslot_endp = endp;
        m_tslot_p            = tslot;
        fld_start_p          = fstart;
        fhs_abort_p          = abort;
        @(negedge clk_6M);
        fhs_req_p            = 1'b0;
        Master_RX_tslot_endp = 1'b0;
        m_tslot_p            = 1'b0;
        fld_start_p          = 1'b0;
        fhs_abort_p          = 1'b0;
    endtask

    // TX slot start (also a slot boundary) with the given clock; queues the expected field.
    task automatic capture(input logic [27:0] clkv);
        logic [25:0] want;
        want       = clkv[27:2] + 26'd1;
        CLK_master = clkv;
        pulse(0, 1, 1, 0, 0);
        check("snap", 32'(fhs_CLK_snap), 32'(want));
        check("busy_after_snap", 32'(busy), 1);
        for (int i = 0; i < 26; i++) exp_q.push_back(want[i]);
    endtask

    task automatic wait_bits(input int target, input string tag);
        int n = 0;
        while (bits_popped < target && n < 1000) begin
            @(negedge clk_6M);
            n++;
        end
        check(tag, 32'(bits_popped >= target), 1);
    endtask

    task automatic wait_done(input string tag);
        int base = done_cnt;
        int n    = 0;
        while (done_cnt == base && n < 400) begin
            @(negedge clk_6M);
            n++;
        end
        check(tag, done_cnt - base, 1);
    endtask

    initial begin
        int b0, e0, d0, f0;
        logic [25:0] snap_hold;

        step(3);
        check("rst_bit", 32'(clk_bit), 0);
        check("rst_vld", 32'(clk_bit_vld), 0);
        check("rst_snap", 32'(fhs_CLK_snap), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done_p), 0);
        check("rst_err", 32'(err_p), 0);
        rst = 1'b0;
        step(2);

        // Stray fld_start_p / abort in IDLE.
        pulse(0, 0, 0, 1, 1);
        check("idle_ignore_busy", 32'(busy), 0);
        check("idle_abort_no_err", 32'(err_p), 0);

        // Nominal.
        b0 = bits_popped; e0 = err_cnt;
        pulse(1, 0, 0, 0, 0);
        step(3);
        capture(28'h000_1233);
        check("nominal_snap_const", 32'(fhs_CLK_snap), 32'h048D);
        step(240);
        pulse(0, 0, 0, 1, 0);
        wait_done("nominal_done");
        check("nominal_bits", bits_popped - b0, 26);
        check("nominal_no_err", err_cnt - e0, 0);
        check("nominal_idle", 32'(busy), 0);

        // Request coinciding with TX slot start is not captured; then wrap capture.
        b0 = bits_popped;
        CLK_master = 28'h123_4567;
        pulse(1, 1, 1, 0, 0);
        check("early_not_snapped", 32'(fhs_CLK_snap), 32'h048D);
        step(4);
        capture(28'hFFF_FFFF);
        check("wrap_snap_const", 32'(fhs_CLK_snap), 0);
        step(17);
        pulse(0, 0, 0, 1, 0);
        wait_done("wrap_done");
        check("wrap_bits", bits_popped - b0, 26);

        // Timeout after two slot boundaries.
        vld_seen = 1'b0;
        pulse(1, 0, 0, 0, 0);
        step(2);
        capture(28'h0AB_CDEF);
        step(10);
        pulse(0, 0, 1, 0, 0);
        check("tmo_first_no_err", 32'(err_p), 0);
        check("tmo_first_busy", 32'(busy), 1);
        step(10);
        pulse(0, 0, 1, 0, 0);
        check("tmo_err", 32'(err_p), 1);
        check("tmo_idle", 32'(busy), 0);
        check("tmo_never_vld", 32'(vld_seen), 0);
        check("tmo_q_untouched", exp_q.size(), 26);
        exp_q.delete();

        // Abort after 10 bits, then a fresh transfer.
        b0 = bits_popped; d0 = done_cnt;
        pulse(1, 0, 0, 0, 0);
        capture(28'h5A5_A5A7);
        snap_hold = fhs_CLK_snap;
        step(20);
        pulse(0, 0, 0, 1, 0);
        wait_bits(b0 + 10, "abort_wait10");
        pulse(0, 0, 0, 0, 1);
        check("abort_vld", 32'(clk_bit_vld), 0);
        check("abort_err", 32'(err_p), 1);
        check("abort_idle", 32'(busy), 0);
        check("abort_snap_kept", 32'(fhs_CLK_snap), 32'(snap_hold));
        check("abort_q_left", exp_q.size(), 16);
        exp_q.delete();
        step(30);
        check("abort_no_done", done_cnt - d0, 0);
        b0 = bits_popped;
        pulse(1, 0, 0, 0, 0);
        step(5);
        capture(28'h7C3_18E2);
        step(9);
        pulse(0, 0, 0, 1, 0);
        wait_done("after_abort_done");
        check("after_abort_bits", bits_popped - b0, 26);

        // fld_start_p with m_tslot_p at slot count 1; fhs_req_p during SHIFT.
        b0 = bits_popped; e0 = err_cnt; f0 = busy_falls;
        pulse(1, 0, 0, 0, 0);
        capture(28'h2D4_9B31);
        step(7);
        pulse(0, 0, 1, 0, 0);
        step(7);
        pulse(0, 0, 1, 1, 0);
        check("coll_no_err", 32'(err_p), 0);
        check("coll_busy", 32'(busy), 1);
        wait_bits(b0 + 5, "coll_wait5");
        pulse(1, 0, 0, 0, 0);
        check("req_in_shift_busy", 32'(busy), 1);
        wait_done("coll_done");
        check("coll_bits", bits_popped - b0, 26);
        check("coll_err_cnt", err_cnt - e0, 0);
        step(30);
        check("coll_busy_one_fall", busy_falls - f0, 1);
        check("coll_still_idle", 32'(busy), 0);

        // Reset while shifting bit 13.
        b0 = bits_popped; e0 = err_cnt; d0 = done_cnt;
        pulse(1, 0, 0, 0, 0);
        capture(28'h955_0F0D);
        step(3);
        pulse(0, 0, 0, 1, 0);
        wait_bits(b0 + 13, "rst_wait13");
        rst = 1'b1;
        @(negedge clk_6M);
        rst = 1'b0;
        check("mid_rst_bit", 32'(clk_bit), 0);
        check("mid_rst_vld", 32'(clk_bit_vld), 0);
        check("mid_rst_snap", 32'(fhs_CLK_snap), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done_p), 0);
        check("mid_rst_err", 32'(err_p), 0);
        check("mid_rst_q_left", exp_q.size(), 13);
        exp_q.delete();
        step(40);
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_no_err", err_cnt - e0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
